y86_regfile_decode: RTL and testbench

//  Parametrised Y86-64 decode stage plus register file. Selects srcA/srcB from icode/rA/rB and reads two ports.

---
 rtl/y86_regfile_decode_if.sv | 37 +++
 rtl/y86_regfile_decode.sv | 100 ++++++++++
 tb/tb_y86_regfile_decode.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/y86_regfile_decode_if.sv
// Decode/register-file bus: fetch fields and write-back ports in, operands, source indices and register dump out.
// The master modport drives the decode request and write-back ports; the slave modport is the regfile/decode stage.
interface y86_regfile_decode_if #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
);
  logic                    dec_valid;
  logic                    stall;
  logic [3:0]              icode;
  logic [3:0]              rA;
  logic [3:0]              rB;
  logic                    we_e;
  logic [3:0]              dstE;
  logic [DATA_W-1:0]       valE_in;
  logic                    we_m;
  logic [3:0]              dstM;
  logic [DATA_W-1:0]       valM_in;
  logic [3:0]              srcA;
  logic [3:0]              srcB;
  logic [DATA_W-1:0]       valA;
  logic [DATA_W-1:0]       valB;
  logic                    out_valid;
  logic                    out_err;
  logic [NREGS*DATA_W-1:0] reg_dump;

  modport master (
    output dec_valid, stall, icode, rA, rB,
    output we_e, dstE, valE_in, we_m, dstM, valM_in,
    input  srcA, srcB, valA, valB, out_valid, out_err, reg_dump
  );

  modport slave (
    input  dec_valid, stall, icode, rA, rB,
    input  we_e, dstE, valE_in, we_m, dstM, valM_in,
    output srcA, srcB, valA, valB, out_valid, out_err, reg_dump
  );
endinterface

// File: rtl/y86_regfile_decode.sv
// Y86-64 decode + dual-write register file; operands registered with 1-cycle latency, held while stall=1.
// REGFILE_BYPASS_EN: same-cycle write data forwarded into the capture (M over E); otherwise the old value is read.
module y86_regfile_decode #(
  parameter int         DATA_W   = 64,
  parameter int         NREGS    = 15,
  parameter logic [3:0] RSP_IDX  = 4'd4,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input  logic                clk,
  input  logic                rst_n,
  y86_regfile_decode_if.slave bus
);
  localparam logic [4:0] NREGS_W = 5'(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              err_a, err_b;

  function automatic logic in_range(input logic [3:0] idx);
    return (idx != REG_NONE) && ({1'b0, idx} < NREGS_W);
  endfunction

  function automatic logic bad_idx(input logic [3:0] idx);
    return (idx != REG_NONE) && ({1'b0, idx} >= NREGS_W);
  endfunction

  always_comb begin
    bus.srcA = REG_NONE;
    bus.srcB = REG_NONE;
    case (bus.icode)
      4'h2:    bus.srcA = bus.rA;
      4'h4:    begin bus.srcA = bus.rA;  bus.srcB = bus.rB;  end
      4'h5:    bus.srcB = bus.rB;
      4'h6:    begin bus.srcA = bus.rA;  bus.srcB = bus.rB;  end
      4'h8:    bus.srcB = RSP_IDX;
      4'h9:    begin bus.srcA = RSP_IDX; bus.srcB = RSP_IDX; end
      4'hA:    begin bus.srcA = bus.rA;  bus.srcB = RSP_IDX; end
      4'hB:    begin bus.srcA = RSP_IDX; bus.srcB = RSP_IDX; end
      default: ;
    endcase
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (in_range(idx)) begin
      v = regs[idx];
`ifdef REGFILE_BYPASS_EN
      if (bus.we_m && bus.dstM == idx)
        v = bus.valM_in;
      else if (bus.we_e && bus.dstE == idx)
        v = bus.valE_in;
`endif
    end
    return v;
  endfunction

  always_comb begin
    rd_a  = rd_port(bus.srcA);
    rd_b  = rd_port(bus.srcB);
    err_a = bad_idx(bus.srcA);
    err_b = bad_idx(bus.srcB);
  end

  // M is assigned after E so it wins when both target the same register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= DATA_W'(i);
    end else begin
      if (bus.we_e && in_range(bus.dstE))
        regs[bus.dstE] <= bus.valE_in;
      if (bus.we_m && in_range(bus.dstM))
        regs[bus.dstM] <= bus.valM_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.valA      <= '0;
      bus.valB      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.dec_valid) begin
        bus.valA      <= rd_a;
        bus.valB      <= rd_b;
        bus.out_valid <= 1'b1;
        bus.out_err   <= err_a | err_b;
      end else begin
        bus.out_valid <= 1'b0;
        bus.out_err   <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_dump
    assign bus.reg_dump[g*DATA_W +: DATA_W] = regs[g];
  end
endmodule

// File: tb/tb_y86_regfile_decode.sv
// Directed bench for y86_regfile_decode; NREGS=14 so that index 4'hE is out of range.
module tb_y86_regfile_decode;
  localparam int DW = 64;
  localparam int NR = 14;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  y86_regfile_decode_if #(.DATA_W(DW), .NREGS(NR)) bus ();

  y86_regfile_decode #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] reg_at(input int i);
    return bus.reg_dump[i*DW +: DW];
  endfunction

  task automatic idle_writes();
    bus.we_e = 1'b0; bus.dstE = 4'hF; bus.valE_in = '0;
    bus.we_m = 1'b0; bus.dstM = 4'hF; bus.valM_in = '0;
  endtask

  logic [63:0] exp_byp;

  initial begin
    rst_n = 1'b0;
    bus.dec_valid = 1'b0; bus.stall = 1'b0;
    bus.icode = 4'h0; bus.rA = 4'hF; bus.rB = 4'hF;
    idle_writes();
    tick();
    rst_n = 1'b1;

    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_valA", bus.valA, 64'd0);
    chk("rst_valB", bus.valB, 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_reg5", reg_at(5), 64'd5);
    chk("rst_reg13", reg_at(13), 64'd13);

    // OPq rA=2 rB=3
    bus.dec_valid = 1'b1; bus.icode = 4'h6; bus.rA = 4'h2; bus.rB = 4'h3;
    #1;
    chk("opq_srcA", 64'(bus.srcA), 64'd2);
    chk("opq_srcB", 64'(bus.srcB), 64'd3);
    tick();
    chk("opq_valA", bus.valA, 64'd2);
    chk("opq_valB", bus.valB, 64'd3);
    chk("opq_valid", 64'(bus.out_valid), 64'd1);

    // Dual write to the same index: M wins
    bus.dec_valid = 1'b0;
    bus.we_e = 1'b1; bus.dstE = 4'h4; bus.valE_in = 64'h11;
    bus.we_m = 1'b1; bus.dstM = 4'h4; bus.valM_in = 64'h22;
    tick();
    chk("dual_reg4", reg_at(4), 64'h22);
    chk("bubble_valid", 64'(bus.out_valid), 64'd0);
    chk("bubble_valA_hold", bus.valA, 64'd2);

    // Dual write to different indices
    bus.dstE = 4'h6; bus.valE_in = 64'h66;
    bus.dstM = 4'h7; bus.valM_in = 64'h77;
    tick();
    idle_writes();
    chk("dual_reg6", reg_at(6), 64'h66);
    chk("dual_reg7", reg_at(7), 64'h77);

    // popq reads %rsp on both ports
    bus.dec_valid = 1'b1; bus.icode = 4'hB; bus.rA = 4'h0; bus.rB = 4'hF;
    #1;
    chk("popq_srcA", 64'(bus.srcA), 64'd4);
    chk("popq_srcB", 64'(bus.srcB), 64'd4);
    tick();
    chk("popq_valA", bus.valA, 64'h22);
    chk("popq_valB", bus.valB, 64'h22);

    // Same-cycle write and capture of reg2
    bus.icode = 4'h6; bus.rA = 4'h2; bus.rB = 4'h3;
    bus.we_e = 1'b1; bus.dstE = 4'h2; bus.valE_in = 64'hAB;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 64'hAB;
`else
    exp_byp = 64'h2;
`endif
    tick();
    idle_writes();
    chk("rw_same_valA", bus.valA, exp_byp);
    chk("rw_same_valB", bus.valB, 64'd3);
    tick();
    chk("rw_next_valA", bus.valA, 64'hAB);

    // pushq rA=1, then stall 3 cycles while writing reg1
    bus.icode = 4'hA; bus.rA = 4'h1; bus.rB = 4'hF;
    #1;
    chk("push_srcB", 64'(bus.srcB), 64'd4);
    tick();
    chk("push_valA", bus.valA, 64'd1);
    chk("push_valB", bus.valB, 64'h22);
    bus.stall = 1'b1; bus.dec_valid = 1'b0;
    bus.we_e = 1'b1; bus.dstE = 4'h1; bus.valE_in = 64'h55;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_valA", k), bus.valA, 64'd1);
      chk($sformatf("stall%0d_valid", k), 64'(bus.out_valid), 64'd1);
    end
    idle_writes();
    chk("stall_reg1", reg_at(1), 64'h55);
    bus.stall = 1'b0;
    tick();
    chk("release_valid", 64'(bus.out_valid), 64'd0);
    chk("release_valA", bus.valA, 64'd1);

    // Out-of-range source
    bus.dec_valid = 1'b1; bus.icode = 4'h2; bus.rA = 4'hE; bus.rB = 4'h0;
    #1;
    chk("oor_srcA", 64'(bus.srcA), 64'hE);
    chk("oor_srcB", 64'(bus.srcB), 64'hF);
    tick();
    chk("oor_valA", bus.valA, 64'd0);
    chk("oor_err", 64'(bus.out_err), 64'd1);
    chk("oor_valid", 64'(bus.out_valid), 64'd1);

    // halt: no sources, error clears
    bus.icode = 4'h0;
    #1;
    chk("halt_srcA", 64'(bus.srcA), 64'hF);
    chk("halt_srcB", 64'(bus.srcB), 64'hF);
    tick();
    chk("halt_err", 64'(bus.out_err), 64'd0);
    chk("halt_valB", bus.valB, 64'd0);

    // Out-of-range write destination is dropped without error
    bus.dec_valid = 1'b0;
    bus.we_e = 1'b1; bus.dstE = 4'hE; bus.valE_in = 64'hDEAD;
    tick();
    idle_writes();
    chk("oor_dst_reg13", reg_at(13), 64'd13);
    chk("oor_dst_err", 64'(bus.out_err), 64'd0);

    // Reset mid-stream overrides write and capture
    bus.we_e = 1'b1; bus.dstE = 4'h5; bus.valE_in = 64'h99;
    tick();
    chk("pre_rst_reg5", reg_at(5), 64'h99);
    bus.dec_valid = 1'b1; bus.icode = 4'h6; bus.rA = 4'h5; bus.rB = 4'h5;
    bus.valE_in = 64'h1234;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_writes();
    bus.dec_valid = 1'b0;
    chk("mid_rst_reg5", reg_at(5), 64'd5);
    chk("mid_rst_reg1", reg_at(1), 64'd1);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_valA", bus.valA, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
